// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default frame geometry, idle
// line level and the receiver state encoding.
package uart_pkg;

    localparam int unsigned DEFAULT_OSR       = 8;
    localparam int unsigned DEFAULT_DATA_BITS = 8;
    localparam logic        LINE_IDLE         = 1'b1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitHigh = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_bit_decider.sv
// Per-bit line decision for the UART receiver.
// MAJORITY_VOTE_EN defined : 2-of-3 vote over the synchronised line at mid-1, mid, mid+1.
// MAJORITY_VOTE_EN undefined: single sample at mid, registered.
// In both builds the decision is valid in the cycle where tick_i == OSR/2 + 1.
module uart_bit_decider
    import uart_pkg::*;
#(
    parameter int unsigned OSR   = DEFAULT_OSR,
    parameter int unsigned TickW = $clog2(OSR)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_rx_i,
    input  logic [TickW-1:0] tick_i,
    output logic             bit_o
);

    localparam logic [TickW-1:0] MidTick = TickW'(OSR / 2);

`ifdef MAJORITY_VOTE_EN
    localparam logic [TickW-1:0] EarlyTick = TickW'(OSR / 2 - 1);

    logic early_q, early_d;
    logic mid_q, mid_d;

    // Capture mid-1 and mid; the mid+1 sample is the live line in the decision cycle.
    always_comb begin
        early_d = early_q;
        mid_d   = mid_q;
        if (tick_i == EarlyTick) early_d = s_rx_i;
        if (tick_i == MidTick)   mid_d   = s_rx_i;
    end

    // Sample window registers, idle-high after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            early_q <= LINE_IDLE;
            mid_q   <= LINE_IDLE;
        end else begin
            early_q <= early_d;
            mid_q   <= mid_d;
        end
    end

    // Majority of the three samples.
    always_comb begin
        bit_o = (early_q & mid_q) | (early_q & s_rx_i) | (mid_q & s_rx_i);
    end
`else
    logic sample_q, sample_d;

    // Hold the mid-bit sample until the decision cycle.
    always_comb begin
        sample_d = sample_q;
        if (tick_i == MidTick) sample_d = s_rx_i;
    end

    // Mid-bit sample register, idle-high after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= LINE_IDLE;
        end else begin
            sample_q <= sample_d;
        end
    end

    // Decision is the registered mid sample.
    always_comb begin
        bit_o = sample_q;
    end
`endif

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer on the oversampling clock. Synchronises RsRx, hunts the
// start edge, decides start/data/stop bits at mid-bit and hands the byte out over
// valid/ready, pulsing frame_err and overrun on bad stop bits and dropped bytes.
// Optional MAJORITY_VOTE_EN selects 2-of-3 bit voting inside uart_bit_decider.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned OSR       = DEFAULT_OSR,
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 sample_clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned      TickW      = $clog2(OSR);
    localparam int unsigned      BitW       = $clog2(DATA_BITS + 2);
    localparam logic [TickW-1:0] DecideTick = TickW'(OSR / 2 + 1);
    localparam logic [TickW-1:0] LastTick   = TickW'(OSR - 1);
    localparam logic [BitW-1:0]  LastBit    = BitW'(DATA_BITS - 1);

    logic sync1_q, sync1_d;
    logic s_rx_q, s_rx_d;
    logic prev_q, prev_d;

    rx_state_e state_q, state_d;

    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic fall_edge;
    logic decide;
    logic bit_dec;

    uart_bit_decider #(
        .OSR   (OSR),
        .TickW (TickW)
    ) u_decider (
        .clk_i  (sample_clk),
        .rst_i  (rst),
        .s_rx_i (s_rx_q),
        .tick_i (tick_q),
        .bit_o  (bit_dec)
    );

    // Two-flop synchroniser plus previous-line flop for edge detection.
    always_comb begin
        sync1_d   = RsRx;
        s_rx_d    = sync1_q;
        prev_d    = s_rx_q;
        fall_edge = prev_q & ~s_rx_q;
        decide    = (tick_q == DecideTick);
    end

    // Synchroniser registers reset to the idle line level.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            sync1_q <= LINE_IDLE;
            s_rx_q  <= LINE_IDLE;
            prev_q  <= LINE_IDLE;
        end else begin
            sync1_q <= sync1_d;
            s_rx_q  <= s_rx_d;
            prev_q  <= prev_d;
        end
    end

    // State register.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: every bit transition happens on its decision cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (fall_edge) state_d = StStart;
            end
            StStart: begin
                if (decide) state_d = bit_dec ? StIdle : StData;
            end
            StData: begin
                if (decide && (bit_cnt_q == LastBit)) state_d = StStop;
            end
            StStop: begin
                if (decide) state_d = bit_dec ? StIdle : StWaitHigh;
            end
            StWaitHigh: begin
                if (s_rx_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and datapath next-state: tick/bit counters, shifter, handshake.
    always_comb begin
        busy        = (state_q != StIdle);
        tick_d      = '0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Tick runs only while staying inside a frame; a fresh START begins at 0.
        if ((state_q != StIdle) &&
            ((state_d == StStart) || (state_d == StData) || (state_d == StStop))) begin
            tick_d = (tick_q == LastTick) ? '0 : tick_q + 1'b1;
        end

        if (state_q == StIdle) bit_cnt_d = '0;

        if ((state_q == StData) && decide) begin
            shift_d   = {bit_dec, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + 1'b1;
        end

        if ((state_q == StStop) && decide) begin
            if (!bit_dec) begin
                frame_err_d = 1'b1;
            end else if (rx_valid_q && !rx_ready) begin
                // Unread byte wins; the new one is dropped.
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            tick_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
